sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock synchronous FIFO buffering `DATA_WIDTH`-bit words between a producer and a consumer in the same clock domain. Depth is a power of two. Writes and reads use independent enable strobes. Full and empty flags provide flow control. Read data is registered.

## Interface
- `DATA_WIDTH`, default 8: width of each stored word.
- `DEPTH`, default 8: number of entries; must be a power of two, ≥ 2.
- `ADDR_WIDTH`, default `$clog2(DEPTH)`: derived; never overridden.

Ports:
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the `clk` rising edge; 0 = reset.
- `wr_en`  in  1  write request; accepted when `!full`.
- `data_in`  in  `DATA_WIDTH`  write data, sampled with `wr_en`.
- `full`  out  1  FIFO holds `DEPTH` words.
- `rd_en`  in  1  read request; accepted when `!empty`.
- `data_out`  out  `DATA_WIDTH`  registered read data.
- `empty`  out  1  FIFO holds zero words.

## Operation
- Storage: array of `DEPTH` words, write pointer and read pointer, each `ADDR_WIDTH+1` bits (the extra MSB is the wrap bit).
- Accepted write (`wr_en && !full`): `mem[wptr[ADDR_WIDTH-1:0]] <= data_in`, then `wptr <= wptr+1`.
- Accepted read (`rd_en && !empty`): `data_out <= mem[rptr[ADDR_WIDTH-1:0]]`, then `rptr <= rptr+1`.
- Rejected requests (write while full, read while empty) are silently dropped; no state changes.
- `data_out` holds its last value when no read is accepted.
- `empty` = (`wptr == rptr`).
- `full` = (low bits of the two pointers equal) and (MSBs differ).
- Pointers wrap modulo 2·`DEPTH` naturally, with no special case.
- Simultaneous `wr_en` and `rd_en`:
  - Both are evaluated against the flags from before the edge.
  - If neither flag blocks, both proceed and occupancy is unchanged.
  - When empty, only the write proceeds; the read is dropped and `data_out` is unchanged.
  - When full, only the read proceeds; the write is dropped, with no pass-through.
- Reset (`reset == 0` at an edge) clears both pointers to 0 and `data_out` to 0. Memory contents are not cleared.
- Reset overrides any concurrent `wr_en`/`rd_en`. Reset mid-operation discards all contents.

## Timing
- Reset values: `empty=1`, `full=0`, `data_out=0`.
- Flags are combinational decodes of registered pointers. They update in the same cycle as the edge that moves the pointers.
- Write-to-not-empty: `empty` falls right after the edge that accepts the first write.
- Read latency: 1 cycle. `data_out` is valid after the edge at which `rd_en && !empty` was sampled.
- `full` rises after the edge accepting the `DEPTH`-th outstanding write. It falls after the next accepted read.
- Throughput: one write and one read per cycle.

## Configuration
- `SYNC_FIFO_ERR_FLAGS_EN`
  - Defined: adds output ports `overflow` (1) and `underflow` (1).
  - `overflow` is set at the edge where `wr_en && full`; `underflow` is set at the edge where `rd_en && empty`.
  - Both flags are sticky until reset, and reset to 0.
  - Undefined: these ports and their logic are absent; all other behaviour is identical.

## Structure
- Package `sync_fifo_pkg`: default `DATA_WIDTH`/`DEPTH` constants and a `ptr_t`-style width helper for pointer width.
- Sub-module `sync_fifo_ram`: a `DEPTH`×`DATA_WIDTH` single-clock memory with a synchronous write port and a registered read port. Pointer and flag logic stay in `sync_fifo`.

## Test plan
- Reset held low 1 cycle → `empty=1`, `full=0`, `data_out=0`.
- Write 0..7 on 8 consecutive cycles (`rd_en=0`) → `empty` falls after the first edge and `full` rises after the 8th edge. A 9th write with `data_in=8'hAA` is dropped.
- Then read 8 consecutive cycles (`wr_en=0`) → `data_out` is 0,1,…,7, one cycle after each read. `full` falls after the first read and `empty` rises after the 8th. An extra read leaves `data_out=7`.
- Simultaneous `wr_en`/`rd_en` with 3 entries → occupancy stays 3 and data order is preserved. When empty, the write is accepted and `data_out` is unchanged. When full, the read is accepted, the write is dropped, and `full` falls.
- Pointer wrap: 50 cycles of random `wr_en`/`rd_en`/`data_in` checked against a queue model. Data order, `full`, and `empty` must match every cycle, across multiple wraps.
- Reset asserted with 5 entries stored and `wr_en=rd_en=1` → after the edge, `empty=1`, `data_out=0`, and the entries are lost. With `SYNC_FIFO_ERR_FLAGS_EN` defined, a write while full sets `overflow` and a read while empty sets `underflow`, and both clear on reset.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared defaults and pointer-width helper for the sync_fifo block.
// Optional error flags are enabled with the SYNC_FIFO_ERR_FLAGS_EN macro (see sync_fifo.sv).
package sync_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 8;

    // Pointer carries one extra wrap bit above the address bits.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x DATA_WIDTH single-clock storage: synchronous write port and a
// registered read port whose output register clears on reset and holds when idle.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage is deliberately left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and registered read data.
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int PTR_W = ptr_width(DEPTH);

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic             wr_acc;
    logic             rd_acc;

    // Both requests are qualified by the flags as they stood before the edge.
    assign empty  = (wptr_q == rptr_q);
    assign full   = (wptr_q[PTR_W-2:0] == rptr_q[PTR_W-2:0]) &&
                    (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]);
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_acc) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (rd_acc) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (wr_acc),
        .waddr_i (wptr_q[ADDR_WIDTH-1:0]),
        .wdata_i (data_in),
        .re_i    (rd_acc),
        .raddr_i (rptr_q[ADDR_WIDTH-1:0]),
        .rdata_o (data_out)
    );

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    always_comb begin
        ovf_d = ovf_q | (wr_en & full);
        unf_d = unf_q | (rd_en & empty);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed-vector and model-based bench for sync_fifo (DATA_WIDTH=8, DEPTH=8).
// Error-flag checks are compiled in when SYNC_FIFO_ERR_FLAGS_EN is defined.
module tb_sync_fifo;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic       overflow;
    logic       underflow;
`endif

    int errors = 0;
    int checks = 0;

    sync_fifo #(
        .DATA_WIDTH (8),
        .DEPTH      (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .data_in   (data_in),
        .full      (full),
        .rd_en     (rd_en),
        .data_out  (data_out),
        .empty     (empty)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        ,
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst_n;
        logic       wr;
        logic       rd;
        logic [7:0] din;
        logic       exp_empty;
        logic       exp_full;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic rd, input logic [7:0] d);
        reset   = r;
        wr_en   = w;
        rd_en   = rd;
        data_in = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic e, input logic f, input logic [7:0] d);
        chk({tag, ".empty"}, empty, e);
        chk({tag, ".full"}, full, f);
        chk({tag, ".data_out"}, data_out, d);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int     n;
        logic [7:0] q[$];
        logic [7:0] exp_d;

        drive(1'b1, 1'b0, 1'b0, 8'h00);

        // Directed fill/drain table: expectations are the state after each edge.
        vecs[0] = '{"reset", 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
        for (int i = 0; i < 8; i++)
            vecs[1+i] = '{$sformatf("wr%0d", i), 1'b1, 1'b1, 1'b0, 8'(i),
                          1'b0, (i == 7), 8'h00};
        vecs[9] = '{"wr_full_drop", 1'b1, 1'b1, 1'b0, 8'hAA, 1'b0, 1'b1, 8'h00};
        for (int i = 0; i < 8; i++)
            vecs[10+i] = '{$sformatf("rd%0d", i), 1'b1, 1'b0, 1'b1, 8'h00,
                           (i == 7), 1'b0, 8'(i)};
        vecs[18] = '{"rd_empty_drop", 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h07};

        @(negedge clk);
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].rst_n, vecs[i].wr, vecs[i].rd, vecs[i].din);
            step();
            chk_state(vecs[i].name, vecs[i].exp_empty, vecs[i].exp_full, vecs[i].exp_dout);
        end

        // Simultaneous read/write with 3 entries stored.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'(8'h10 + i));
            step();
        end
        drive(1'b1, 1'b1, 1'b1, 8'h13); step();
        chk_state("sim3_a", 1'b0, 1'b0, 8'h10);
        drive(1'b1, 1'b1, 1'b1, 8'h14); step();
        chk_state("sim3_b", 1'b0, 1'b0, 8'h11);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, 8'h00); step();
            chk_state($sformatf("sim3_drain%0d", i), (i == 2), 1'b0, 8'(8'h12 + i));
        end

        // Simultaneous on empty: write lands, read dropped, data_out holds.
        drive(1'b1, 1'b1, 1'b1, 8'h20); step();
        chk_state("sim_empty", 1'b0, 1'b0, 8'h14);
        drive(1'b1, 1'b0, 1'b1, 8'h00); step();
        chk_state("sim_empty_rd", 1'b1, 1'b0, 8'h20);

        // Simultaneous on full: read proceeds, write of 99 dropped.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'(8'h30 + i)); step();
        end
        chk("fill_full", full, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 8'h99); step();
        chk_state("sim_full", 1'b0, 1'b0, 8'h30);
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b0, 1'b1, 8'h00); step();
            chk_state($sformatf("sim_full_drain%0d", i), (i == 6), 1'b0, 8'(8'h31 + i));
        end

        // Random traffic against a queue model, crossing several pointer wraps.
        exp_d = 8'h37;
        for (int c = 0; c < 50; c++) begin
            logic w, r;
            logic [7:0] d;
            logic wa, ra;
            w  = ($urandom_range(0, 9) < 6);
            r  = ($urandom_range(0, 9) < 5);
            d  = 8'($urandom);
            wa = w && (q.size() < 8);
            ra = r && (q.size() > 0);
            if (ra) exp_d = q.pop_front();
            if (wa) q.push_back(d);
            drive(1'b1, w, r, d); step();
            chk_state($sformatf("rand%0d", c), (q.size() == 0), (q.size() == 8), exp_d);
        end

        // Reset mid-operation with 5 entries and both strobes high.
        drive(1'b0, 1'b0, 1'b0, 8'h00); step();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'(8'h40 + i)); step();
        end
        chk("five_stored_empty", empty, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 8'h77); step();
        chk_state("mid_reset", 1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b1, 8'h00); step();
        chk_state("after_reset_rd", 1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 8'h55); step();
        drive(1'b1, 1'b0, 1'b1, 8'h00); step();
        chk_state("after_reset_wr_rd", 1'b1, 1'b0, 8'h55);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
        drive(1'b0, 1'b0, 1'b0, 8'h00); step();
        chk("ovf_reset", overflow, 1'b0);
        chk("unf_reset", underflow, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 8'h00); step();
        chk("unf_set", underflow, 1'b1);
        chk("ovf_still0", overflow, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'(i)); step();
        end
        chk("ovf_not_yet", overflow, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 8'hEE); step();
        chk("ovf_set", overflow, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 8'h00); step();
        chk("ovf_sticky", overflow, 1'b1);
        chk("unf_sticky", underflow, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 8'h00); step();
        chk("ovf_cleared", overflow, 1'b0);
        chk("unf_cleared", underflow, 1'b0);
`endif

        n = errors;
        $display("Result: errors=%0d of %0d checks", n, checks);
        $finish;
    end

endmodule
